// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC and the IF/ID register, and
//            handles stalls, flushes, redirects, end-of-memory halt and errors.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 64,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc_out,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic             misaligned_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      C_LAST_PC = 32'(IMEM_BYTES - 4);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      r_instr;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_pc4;
    logic             r_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_tgt_misaligned;
    logic        w_tgt_in_range;
    logic [31:0] w_pc_plus4;
    logic        w_at_end;
    logic        w_latch;
    logic        w_set_err;

    assign w_redirect       = jump | branch_taken;
    assign w_target         = jump ? jump_target : branch_target;
    assign w_tgt_misaligned = (w_target[1:0] != 2'b00);
    assign w_tgt_in_range   = (w_target <= C_LAST_PC);
    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_at_end         = (w_pc_plus4 > C_LAST_PC);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_latch     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_latch = ~stall;
                if (w_redirect) begin
                    if (w_tgt_misaligned) begin
                        w_state_nxt = ST_ERR;
                        w_set_err   = 1'b1;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (!stall) begin
                    // The final word is still latched; the PC parks on it.
                    if (w_at_end) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            ST_HALT: begin
                if (w_redirect) begin
                    if (w_tgt_misaligned) begin
                        w_state_nxt = ST_ERR;
                        w_set_err   = 1'b1;
                    end else if (w_tgt_in_range) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Flush takes priority over a latch; outside RUN the register only loses validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= 32'd0;
            r_id_pc  <= 32'd0;
            r_id_pc4 <= 32'd0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else begin
            if (flush) begin
                r_instr <= 32'd0;
                r_valid <= 1'b0;
            end else if (w_latch) begin
                r_instr  <= imem_instr;
                r_id_pc  <= r_pc;
                r_id_pc4 <= w_pc_plus4;
                r_valid  <= 1'b1;
                if (!(&r_count)) begin
                    r_count <= r_count + C_CNT_ONE;
                end
            end else if (r_state != ST_RUN) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pc_out         = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_id_pc;
    assign if_id_pc4      = r_id_pc4;
    assign if_id_valid    = r_valid;
    assign halted         = (r_state == ST_HALT);
    assign misaligned_err = r_err;
    assign fetch_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed scoreboard bench for fetch_unit (narrow counter to reach
//            saturation quickly).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_target = 32'd0;
    logic             jump = 1'b0;
    logic [31:0]      jump_target = 32'd0;
    logic [31:0]      imem_instr;
    logic [31:0]      pc_out;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             halted;
    logic             misaligned_err;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        halted;
        logic        err;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (64),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_instr     (imem_instr),
        .pc_out         (pc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .misaligned_err (misaligned_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'd0) return 32'h0000_0013;
        if (a == 32'd4) return 32'h1111_1111;
        return 32'hA000_0000 | a;
    endfunction

    assign imem_instr = word_at(pc_out);

    function automatic exp_t mk(input logic [31:0] pc, input logic valid,
                                input logic [31:0] instr, input logic [31:0] ipc,
                                input logic hlt, input logic err, input int cnt);
        exp_t e;
        e.pc     = pc;
        e.valid  = valid;
        e.instr  = instr;
        e.ipc    = ipc;
        e.ipc4   = ipc + 32'd4;
        e.halted = hlt;
        e.err    = err;
        e.cnt    = (cnt > 15) ? 4'd15 : 4'(cnt);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    pc_out, 32'd0);
        chk({tag, "_instr"}, if_id_instr, 32'd0);
        chk({tag, "_ipc"},   if_id_pc, 32'd0);
        chk({tag, "_ipc4"},  if_id_pc4, 32'd0);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_halt"},  {31'd0, halted}, 32'd0);
        chk({tag, "_err"},   {31'd0, misaligned_err}, 32'd0);
        chk({tag, "_cnt"},   {28'd0, fetch_count}, 32'd0);
    endtask

    // Called just after a negedge: drive inputs, queue the post-edge expectation.
    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input exp_t e);
        stall = s; flush = f; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expectation per checked edge, compared shortly after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                chk("if_id_instr", if_id_instr, e.instr);
                if (e.valid) begin
                    chk("if_id_pc", if_id_pc, e.ipc);
                    chk("if_id_pc4", if_id_pc4, e.ipc4);
                end
                chk("halted", {31'd0, halted}, {31'd0, e.halted});
                chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, e.err});
                chk("fetch_count", {28'd0, fetch_count}, {28'd0, e.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sequential fetch
        step(0, 0, 0, 0, 0, 0, mk(32'd4, 1, 32'h0000_0013, 32'd0, 0, 0, 1));
        step(0, 0, 0, 0, 0, 0, mk(32'd8, 1, 32'h1111_1111, 32'd4, 0, 0, 2));
        // Stall holds everything
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, mk(32'd8, 1, 32'h1111_1111, 32'd4, 0, 0, 2));
        step(0, 0, 0, 0, 0, 0, mk(32'd12, 1, 32'hA000_0008, 32'd8, 0, 0, 3));
        // Branch with flush squashes IF/ID
        step(0, 1, 1, 32'h20, 0, 0, mk(32'h20, 0, 32'd0, 32'd0, 0, 0, 3));
        // Jump beats branch
        step(0, 0, 1, 32'h8, 1, 32'h4, mk(32'h4, 1, 32'hA000_0020, 32'h20, 0, 0, 4));
        // Run to end of memory; counter saturates at 15 along the way
        k = 4;
        for (int a = 4; a <= 56; a += 4) begin
            k++;
            step(0, 0, 0, 0, 0, 0, mk(32'(a + 4), 1, word_at(32'(a)), 32'(a), 0, 0, k));
        end
        step(0, 0, 0, 0, 0, 0, mk(32'd60, 1, 32'hA000_003C, 32'd60, 1, 0, 19));
        step(0, 0, 0, 0, 0, 0, mk(32'd60, 0, 32'hA000_003C, 32'd0, 1, 0, 19));
        // Out-of-range redirect in HALT is ignored
        step(0, 0, 0, 0, 1, 32'h40, mk(32'd60, 0, 32'hA000_003C, 32'd0, 1, 0, 19));
        step(0, 0, 0, 0, 1, 32'h10, mk(32'h10, 0, 32'hA000_003C, 32'd0, 0, 0, 19));
        step(0, 0, 0, 0, 0, 0, mk(32'h14, 1, 32'hA000_0010, 32'h10, 0, 0, 19));
        // Misaligned jump -> ERR, then legal jumps are ignored
        step(1, 0, 0, 0, 1, 32'h6, mk(32'h14, 1, 32'hA000_0010, 32'h10, 0, 1, 19));
        step(0, 0, 0, 0, 1, 32'h8, mk(32'h14, 0, 32'hA000_0010, 32'd0, 0, 1, 19));
        step(0, 0, 0, 0, 0, 0, mk(32'h14, 0, 32'hA000_0010, 32'd0, 0, 1, 19));

        // Reset pulse clears ERR
        rst_n = 1'b0;
        #1;
        chk_reset("err_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a <= 32; a += 4)
            step(0, 0, 0, 0, 0, 0, mk(32'(a + 4), 1, word_at(32'(a)), 32'(a), 0, 0, a / 4 + 1));
        for (int i = 0; i < 2; i++)
            step(1, 0, 0, 0, 0, 0, mk(32'h24, 1, 32'hA000_0020, 32'h20, 0, 0, 9));
        // Asynchronous reset mid-stall, between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
